count_checker: RTL and testbench

- Synthesizable self-checking responder for the T-enabled 4-bit counter stimulus interface.
- Observes the same `T`, `reset` and `q` nets the stimulus drives and monitors.
- Keeps a cycle-accurate reference count and flags any mismatch between `q` and the expected value.
- Reports error, wrap and first-failure status, so benches and on-chip debug need no `$monitor` inspection.

---
 rtl/count_checker.sv | 88 ++++++++
 tb/tb_count_checker.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/count_checker.sv
// Self-checking responder for a T-enabled counter: tracks a reference count and flags mismatches on q.
// Optional macro CHK_FREEZE_EN: the first mismatch locks the checker in FAIL until reset.
module count_checker #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned ECW   = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             T,
  input  logic [WIDTH-1:0] q,
  output logic             err,
  output logic             err_pulse,
  output logic [ECW-1:0]   err_count,
  output logic [ECW-1:0]   wrap_count,
  output logic [WIDTH-1:0] first_exp,
  output logic [WIDTH-1:0] first_got,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    SYNC = 2'd0,
    HOLD = 2'd1,
    RUN  = 2'd2,
    FAIL = 2'd3
  } state_t;

  state_t           st;
  logic [WIDTH-1:0] exp_q;
  logic             t_d;
  logic             mismatch;
  logic             wrap;
  logic [WIDTH-1:0] t_d_ext;

  // Case inequality so an X/Z on q is reported as a mismatch in simulation.
  always_comb begin
    mismatch = (q !== exp_q);
    wrap     = t_d && (exp_q == '1);
    t_d_ext  = {{(WIDTH-1){1'b0}}, t_d};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      st         <= SYNC;
      exp_q      <= '0;
      t_d        <= 1'b0;
      err        <= 1'b0;
      err_pulse  <= 1'b0;
      err_count  <= '0;
      wrap_count <= '0;
      first_exp  <= '0;
      first_got  <= '0;
    end else if (st != FAIL) begin
      t_d       <= T;
      err_pulse <= mismatch;
      exp_q     <= exp_q + t_d_ext;
      if (wrap && (wrap_count != '1))
        wrap_count <= wrap_count + ECW'(1);

      case (st)
        SYNC:    st <= T ? RUN : HOLD;
        HOLD:    if (T)  st <= RUN;
        RUN:     if (!T) st <= HOLD;
        default: st <= st;
      endcase

      // Mismatch handling overrides the model update and state step above.
      if (mismatch) begin
        err <= 1'b1;
        if (err_count != '1)
          err_count <= err_count + ECW'(1);
        if (!err) begin
          first_exp <= exp_q;
          first_got <= q;
        end
`ifdef CHK_FREEZE_EN
        st <= FAIL;
`else
        exp_q <= q + t_d_ext;
`endif
      end
    end else begin
      err_pulse <= 1'b0;
    end
  end

  assign state = st;

endmodule

// File: tb/tb_count_checker.sv
// Directed bench for count_checker: good counter, glitches, mid-run reset, wrap, error-count saturation.
module tb_count_checker;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       T = 1'b0;
  logic [3:0] q = 4'd0;
  logic       err, err_pulse;
  logic [7:0] err_count, wrap_count;
  logic [3:0] first_exp, first_got;
  logic [1:0] state;

  logic       sat_reset = 1'b1;
  logic       sat_T = 1'b0;
  logic [3:0] sat_q = 4'd0;
  logic       sat_err, sat_err_pulse;
  logic [1:0] sat_err_count, sat_wrap_count;
  logic [3:0] sat_first_exp, sat_first_got;
  logic [1:0] sat_state;

  int checks = 0;
  int failures = 0;

  // Stimulus counter honouring the one-cycle contract: q at edge k counts T up to edge k-2.
  logic [3:0] gq = 4'd0;
  logic       gtd = 1'b0;

  always #5 clock = ~clock;

  count_checker #(.WIDTH(4), .ECW(8)) dut (
    .clock(clock), .reset(reset), .T(T), .q(q),
    .err(err), .err_pulse(err_pulse), .err_count(err_count), .wrap_count(wrap_count),
    .first_exp(first_exp), .first_got(first_got), .state(state)
  );

  count_checker #(.WIDTH(4), .ECW(2)) sat_dut (
    .clock(clock), .reset(sat_reset), .T(sat_T), .q(sat_q),
    .err(sat_err), .err_pulse(sat_err_pulse), .err_count(sat_err_count), .wrap_count(sat_wrap_count),
    .first_exp(sat_first_exp), .first_got(sat_first_got), .state(sat_state)
  );

  task automatic cyc(input logic t_in, input logic [3:0] q_in);
    @(negedge clock);
    reset = 1'b0; T = t_in; q = q_in;
    @(posedge clock); #1;
  endtask

  task automatic good(input logic t_in);
    cyc(t_in, gq);
    gq  = gq + {3'b000, gtd};
    gtd = t_in;
  endtask

  task automatic apply_reset;
    @(negedge clock);
    reset = 1'b1; T = 1'b0; q = 4'd0;
    @(posedge clock); #1;
    gq = 4'd0; gtd = 1'b0;
  endtask

  task automatic test_reset;
    apply_reset();
    apply_reset();
    checks++; if (err !== 1'b0)        begin failures++; $display("FAIL reset_err got=%0h exp=0", err); end
    checks++; if (err_pulse !== 1'b0)  begin failures++; $display("FAIL reset_pulse got=%0h exp=0", err_pulse); end
    checks++; if (err_count !== 8'd0)  begin failures++; $display("FAIL reset_err_count got=%0h exp=0", err_count); end
    checks++; if (wrap_count !== 8'd0) begin failures++; $display("FAIL reset_wrap_count got=%0h exp=0", wrap_count); end
    checks++; if (first_exp !== 4'd0)  begin failures++; $display("FAIL reset_first_exp got=%0h exp=0", first_exp); end
    checks++; if (first_got !== 4'd0)  begin failures++; $display("FAIL reset_first_got got=%0h exp=0", first_got); end
    checks++; if (state !== 2'd0)      begin failures++; $display("FAIL reset_state got=%0h exp=0", state); end
  endtask

  task automatic test_normal;
    logic err_seen;
    err_seen = 1'b0;
    apply_reset();
    good(1'b0);
    err_seen |= err;
    checks++; if (state !== 2'd1) begin failures++; $display("FAIL normal_sync_to_hold got=%0h exp=1", state); end
    for (int i = 0; i < 6; i++) begin
      good(1'b1);
      err_seen |= err;
      if (i == 0) begin
        checks++; if (state !== 2'd2) begin failures++; $display("FAIL normal_hold_to_run got=%0h exp=2", state); end
      end
    end
    for (int i = 0; i < 3; i++) begin
      good(1'b0);
      err_seen |= err;
      if (i == 0) begin
        checks++; if (state !== 2'd1) begin failures++; $display("FAIL normal_run_to_hold got=%0h exp=1", state); end
      end
    end
    for (int i = 0; i < 50; i++) begin
      good(1'b1);
      err_seen |= err;
      if (i == 0) begin
        checks++; if (state !== 2'd2) begin failures++; $display("FAIL normal_hold_to_run2 got=%0h exp=2", state); end
      end
    end
    checks++; if (err_seen !== 1'b0)   begin failures++; $display("FAIL normal_err got=%0h exp=0", err_seen); end
    checks++; if (err_count !== 8'd0)  begin failures++; $display("FAIL normal_err_count got=%0h exp=0", err_count); end
    checks++; if (wrap_count !== 8'd3) begin failures++; $display("FAIL normal_wrap_count got=%0h exp=3", wrap_count); end
  endtask

  task automatic test_glitch;
    logic [3:0] wrong;
    apply_reset();
    for (int i = 0; i < 5; i++) good(1'b1);
    cyc(1'b1, 4'd5);
    checks++; if (err_pulse !== 1'b1)  begin failures++; $display("FAIL glitch_pulse got=%0h exp=1", err_pulse); end
    checks++; if (err !== 1'b1)        begin failures++; $display("FAIL glitch_err got=%0h exp=1", err); end
    checks++; if (err_count !== 8'd1)  begin failures++; $display("FAIL glitch_err_count got=%0h exp=1", err_count); end
    checks++; if (first_exp !== 4'd4)  begin failures++; $display("FAIL glitch_first_exp got=%0h exp=4", first_exp); end
    checks++; if (first_got !== 4'd5)  begin failures++; $display("FAIL glitch_first_got got=%0h exp=5", first_got); end
`ifdef CHK_FREEZE_EN
    checks++; if (state !== 2'd3)      begin failures++; $display("FAIL freeze_state got=%0h exp=3", state); end
    for (int i = 0; i < 3; i++) cyc(1'b1, 4'hC);
    checks++; if (err_count !== 8'd1)  begin failures++; $display("FAIL freeze_err_count got=%0h exp=1", err_count); end
    checks++; if (err_pulse !== 1'b0)  begin failures++; $display("FAIL freeze_pulse got=%0h exp=0", err_pulse); end
    checks++; if (state !== 2'd3)      begin failures++; $display("FAIL freeze_state_hold got=%0h exp=3", state); end
    checks++; if (err !== 1'b1)        begin failures++; $display("FAIL freeze_err got=%0h exp=1", err); end
`else
    gq = 4'd6; gtd = 1'b1;
    good(1'b1);
    checks++; if (err_pulse !== 1'b0)  begin failures++; $display("FAIL resync_pulse got=%0h exp=0", err_pulse); end
    for (int i = 0; i < 3; i++) good(1'b1);
    checks++; if (err_count !== 8'd1)  begin failures++; $display("FAIL resync_err_count got=%0h exp=1", err_count); end
    checks++; if (state !== 2'd2)      begin failures++; $display("FAIL resync_state got=%0h exp=2", state); end
    wrong = gq ^ 4'h8;
    cyc(1'b1, wrong);
    gq = wrong + 4'd1; gtd = 1'b1;
    checks++; if (err_count !== 8'd2)  begin failures++; $display("FAIL second_err_count got=%0h exp=2", err_count); end
    checks++; if (first_exp !== 4'd4)  begin failures++; $display("FAIL second_first_exp got=%0h exp=4", first_exp); end
    checks++; if (first_got !== 4'd5)  begin failures++; $display("FAIL second_first_got got=%0h exp=5", first_got); end
`endif
  endtask

  task automatic test_reset_mid_run;
`ifndef CHK_FREEZE_EN
    for (int i = 0; i < 20 && gq != 4'd9; i++) good(1'b1);
    checks++; if (gq !== 4'd9) begin failures++; $display("FAIL midreset_setup got=%0h exp=9", gq); end
`endif
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL midreset_pre_err got=%0h exp=1", err); end
    apply_reset();
    checks++; if (err !== 1'b0)        begin failures++; $display("FAIL midreset_err got=%0h exp=0", err); end
    checks++; if (err_pulse !== 1'b0)  begin failures++; $display("FAIL midreset_pulse got=%0h exp=0", err_pulse); end
    checks++; if (err_count !== 8'd0)  begin failures++; $display("FAIL midreset_err_count got=%0h exp=0", err_count); end
    checks++; if (wrap_count !== 8'd0) begin failures++; $display("FAIL midreset_wrap_count got=%0h exp=0", wrap_count); end
    checks++; if (first_exp !== 4'd0)  begin failures++; $display("FAIL midreset_first_exp got=%0h exp=0", first_exp); end
    checks++; if (first_got !== 4'd0)  begin failures++; $display("FAIL midreset_first_got got=%0h exp=0", first_got); end
    checks++; if (state !== 2'd0)      begin failures++; $display("FAIL midreset_state got=%0h exp=0", state); end
    good(1'b0);
    checks++; if (err !== 1'b0)        begin failures++; $display("FAIL midreset_release_err got=%0h exp=0", err); end
    checks++; if (state !== 2'd1)      begin failures++; $display("FAIL midreset_release_state got=%0h exp=1", state); end
  endtask

  task automatic test_wrap_stuck;
    apply_reset();
    for (int i = 0; i < 17; i++) good(1'b1);
    checks++; if (wrap_count !== 8'd1) begin failures++; $display("FAIL wrap_count got=%0h exp=1", wrap_count); end
    checks++; if (err !== 1'b0)        begin failures++; $display("FAIL wrap_err got=%0h exp=0", err); end
    cyc(1'b1, 4'hF);
    checks++; if (err !== 1'b1)        begin failures++; $display("FAIL stuck_err got=%0h exp=1", err); end
    checks++; if (err_pulse !== 1'b1)  begin failures++; $display("FAIL stuck_pulse got=%0h exp=1", err_pulse); end
    checks++; if (first_exp !== 4'd0)  begin failures++; $display("FAIL stuck_first_exp got=%0h exp=0", first_exp); end
    checks++; if (first_got !== 4'hF)  begin failures++; $display("FAIL stuck_first_got got=%0h exp=f", first_got); end
    checks++; if (wrap_count !== 8'd1) begin failures++; $display("FAIL stuck_wrap_count got=%0h exp=1", wrap_count); end
  endtask

  task automatic test_saturation;
    logic       exp_pulse;
    logic [1:0] exp_cnt;
    @(negedge clock);
    sat_reset = 1'b1; sat_T = 1'b0; sat_q = 4'd0;
    @(posedge clock); #1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      sat_reset = 1'b0; sat_T = 1'b0;
      sat_q = i[0] ? 4'h5 : 4'hA;
      @(posedge clock); #1;
`ifdef CHK_FREEZE_EN
      exp_pulse = (i == 0);
      exp_cnt   = 2'd1;
`else
      exp_pulse = 1'b1;
      exp_cnt   = (i >= 2) ? 2'd3 : 2'(i + 1);
`endif
      checks++; if (sat_err_pulse !== exp_pulse) begin failures++; $display("FAIL sat_pulse[%0d] got=%0h exp=%0h", i, sat_err_pulse, exp_pulse); end
      checks++; if (sat_err_count !== exp_cnt)   begin failures++; $display("FAIL sat_count[%0d] got=%0h exp=%0h", i, sat_err_count, exp_cnt); end
    end
    checks++; if (sat_err !== 1'b1)       begin failures++; $display("FAIL sat_err got=%0h exp=1", sat_err); end
    checks++; if (sat_first_exp !== 4'd0) begin failures++; $display("FAIL sat_first_exp got=%0h exp=0", sat_first_exp); end
    checks++; if (sat_first_got !== 4'hA) begin failures++; $display("FAIL sat_first_got got=%0h exp=a", sat_first_got); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_normal();
    test_glitch();
    test_reset_mid_run();
    test_wrap_stuck();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
